cursor_controller: RTL and testbench

CURSOR_CONTROLLER -- requirements
Module: cursor_controller

---
 rtl/minesweeper_pkg.sv | 23 ++
 rtl/wrap_counter.sv | 24 ++
 rtl/cursor_controller.sv | 118 +++++++++++
 tb/tb_cursor_controller.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/minesweeper_pkg.sv
// Shared Minesweeper types: cursor FSM states, command opcodes and the command record.
// No logic here. These definitions carry no latency and no flow-control behaviour.
package minesweeper_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_ISSUE = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      OP_NONE   = 2'b00,
      OP_REVEAL = 2'b01,
      OP_FLAG   = 2'b10
   } op_t;

   typedef struct packed {
      op_t        op;
      logic [3:0] row;
      logic [3:0] col;
   } cmd_t;

endpackage

// File: rtl/wrap_counter.sv
// Modulo-MOD up/down counter that wraps at both ends. The new value appears 1 cycle after inc/dec.
// There is no backpressure. If inc and dec are both high, inc takes precedence.
module wrap_counter #(
   parameter int MOD = 8
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       inc,
   input  logic       dec,
   output logic [3:0] value
);

   localparam logic [3:0] LAST = 4'(MOD - 1);

   always_ff @(posedge clock) begin
      if (reset)
         value <= 4'd0;
      else if (inc)
         value <= (value == LAST) ? 4'd0 : value + 4'd1;
      else if (dec)
         value <= (value == 4'd0) ? LAST : value - 4'd1;
   end

endmodule

// File: rtl/cursor_controller.sv
// Cursor and command FSM. Key effects show 1 cycle later. A command rises 1 cycle after the deciding event.
// The command is held under valid/ready until it transfers. Movement keys are dropped while a command is armed or pending.
module cursor_controller
   import minesweeper_pkg::*;
#(
   parameter int ROWS       = 8,
   parameter int COLS       = 8,
   parameter int DOUBLE_WIN = 12500000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] keyPulse,
   input  logic       cmdReady,
   output logic       cmdValid,
   output logic [1:0] cmdOp,
   output logic [3:0] cmdRow,
   output logic [3:0] cmdCol,
   output logic [3:0] cursorRow,
   output logic [3:0] cursorCol,
   output logic       axisSel
);

   localparam int            CW       = (DOUBLE_WIN > 1) ? $clog2(DOUBLE_WIN) : 1;
   localparam logic [CW-1:0] WIN_LAST = CW'(DOUBLE_WIN - 1);

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          axis_q, axis_d;
   cmd_t          cmd_q;
   op_t           op_d;
   logic          load_cmd;
   logic          row_inc, row_dec, col_inc, col_dec;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         axis_q  <= 1'b0;
         cmd_q   <= '{op: OP_NONE, row: 4'd0, col: 4'd0};
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         axis_q  <= axis_d;
         if (load_cmd)
            cmd_q <= '{op: op_d, row: cursorRow, col: cursorCol};
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      axis_d   = axis_q;
      op_d     = OP_NONE;
      load_cmd = 1'b0;
      row_inc  = 1'b0;
      row_dec  = 1'b0;
      col_inc  = 1'b0;
      col_dec  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // Only the highest-priority key acts; the rest are dropped this cycle.
            if (keyPulse[0]) begin
               cnt_d   = '0;
               state_d = ST_ARMED;
            end else if (keyPulse[1]) begin
               axis_d = ~axis_q;
            end else if (keyPulse[2]) begin
               row_inc = axis_q;
               col_inc = ~axis_q;
            end else if (keyPulse[3]) begin
               row_dec = axis_q;
               col_dec = ~axis_q;
            end
         end
         ST_ARMED: begin
            if (keyPulse[0]) begin
               state_d  = ST_ISSUE;
               op_d     = OP_FLAG;
               load_cmd = 1'b1;
            end else if (cnt_q == WIN_LAST) begin
               state_d  = ST_ISSUE;
               op_d     = OP_REVEAL;
               load_cmd = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_ISSUE: begin
            if (cmdReady)
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   wrap_counter #(.MOD(ROWS)) row_ctr (
      .clock (clock),
      .reset (reset),
      .inc   (row_inc),
      .dec   (row_dec),
      .value (cursorRow)
   );

   wrap_counter #(.MOD(COLS)) col_ctr (
      .clock (clock),
      .reset (reset),
      .inc   (col_inc),
      .dec   (col_dec),
      .value (cursorCol)
   );

   assign cmdValid = (state_q == ST_ISSUE);
   assign cmdOp    = cmdValid ? cmd_q.op : OP_NONE;
   assign cmdRow   = cmd_q.row;
   assign cmdCol   = cmd_q.col;
   assign axisSel  = axis_q;

endmodule

// File: tb/tb_cursor_controller.sv
// Directed bench for cursor_controller on an 8x8 board with a 10-cycle double-press window.
// Each expected command is queued when it is armed and is compared at its valid/ready transfer.
module tb_cursor_controller;

   logic       clock = 1'b0;
   logic       reset;
   logic [3:0] keyPulse;
   logic       cmdReady;
   logic       cmdValid;
   logic [1:0] cmdOp;
   logic [3:0] cmdRow, cmdCol, cursorRow, cursorCol;
   logic       axisSel;

   typedef struct {
      logic [1:0] op;
      logic [3:0] row;
      logic [3:0] col;
   } exp_cmd_t;

   exp_cmd_t sb[$];
   int tests = 0;
   int fails = 0;
   int exp_row = 0, exp_col = 0;
   logic exp_axis = 1'b0;
   int lat;

   cursor_controller #(.ROWS(8), .COLS(8), .DOUBLE_WIN(10)) dut (
      .clock     (clock),
      .reset     (reset),
      .keyPulse  (keyPulse),
      .cmdReady  (cmdReady),
      .cmdValid  (cmdValid),
      .cmdOp     (cmdOp),
      .cmdRow    (cmdRow),
      .cmdCol    (cmdCol),
      .cursorRow (cursorRow),
      .cursorCol (cursorCol),
      .axisSel   (axisSel)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Drive one key pulse in IDLE and step the reference cursor model by key priority.
   task automatic idle_key(input logic [3:0] k);
      keyPulse = k;
      tick();
      keyPulse = 4'b0000;
      if (k[0]) begin
      end else if (k[1]) exp_axis = ~exp_axis;
      else if (k[2]) begin
         if (exp_axis) exp_row = (exp_row + 1) % 8; else exp_col = (exp_col + 1) % 8;
      end else if (k[3]) begin
         if (exp_axis) exp_row = (exp_row + 7) % 8; else exp_col = (exp_col + 7) % 8;
      end
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (!cmdValid && n < 40) begin
         tick();
         n++;
      end
   endtask

   task automatic chk_cursor(input string tag);
      chk({tag, "_row"}, 32'(cursorRow), 32'(exp_row));
      chk({tag, "_col"}, 32'(cursorCol), 32'(exp_col));
      chk({tag, "_axis"}, 32'(axisSel), 32'(exp_axis));
   endtask

   // Transfer monitor: a handshake seen before the edge completes at that edge unless reset is high.
   always @(negedge clock) begin
      if (!reset && cmdValid && cmdReady) begin
         exp_cmd_t e;
         tests++;
         assert (sb.size() > 0) else begin
            fails++;
            $error("FAIL xfer_unexpected observed op=%0h row=%0d col=%0d expected no transfer",
                   cmdOp, cmdRow, cmdCol);
         end
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("xfer_op", 32'(cmdOp), 32'(e.op));
            chk("xfer_row", 32'(cmdRow), 32'(e.row));
            chk("xfer_col", 32'(cmdCol), 32'(e.col));
         end
      end
   end

   initial begin
      reset = 1'b1;
      keyPulse = 4'b0000;
      cmdReady = 1'b0;
      tick();
      tick();
      chk("rst_valid", 32'(cmdValid), 0);
      chk("rst_op", 32'(cmdOp), 0);
      chk("rst_cmdrow", 32'(cmdRow), 0);
      chk("rst_cmdcol", 32'(cmdCol), 0);
      chk_cursor("rst");
      reset = 1'b0;

      // Three decrements on the column axis wrap from 0 down to 5.
      for (int i = 0; i < 3; i++) idle_key(4'b1000);
      chk("dec3_col", 32'(cursorCol), 5);
      chk("dec3_row", 32'(cursorRow), 0);

      // Switch to the row axis, then step it through 7 and back round to 0.
      idle_key(4'b0010);
      chk("toggle_axis", 32'(axisSel), 1);
      for (int i = 0; i < 8; i++) begin
         idle_key(4'b0100);
         chk("inc_row", 32'(cursorRow), 32'((i + 1) % 8));
      end
      chk_cursor("inc_wrap");

      // Move the cursor to (2,3).
      idle_key(4'b0100);
      idle_key(4'b0100);
      idle_key(4'b0010);
      idle_key(4'b1000);
      idle_key(4'b1000);
      chk_cursor("pos23");

      // A ready input held high in IDLE must not cause a transfer.
      cmdReady = 1'b1;
      tick();
      tick();
      chk("ready_idle_valid", 32'(cmdValid), 0);
      cmdReady = 1'b0;

      // A single press should issue REVEAL 11 cycles later and hold it while ready is low.
      sb.push_back('{op: 2'b01, row: 4'd2, col: 4'd3});
      idle_key(4'b0001);
      wait_valid(lat);
      chk("reveal_latency", 32'(lat + 1), 11);
      chk("reveal_op", 32'(cmdOp), 32'h1);
      chk("reveal_row", 32'(cmdRow), 2);
      chk("reveal_col", 32'(cmdCol), 3);
      for (int i = 0; i < 4; i++) begin
         keyPulse = (i == 1) ? 4'b0001 : ((i == 2) ? 4'b0100 : 4'b0000);
         tick();
         keyPulse = 4'b0000;
         chk("hold_valid", 32'(cmdValid), 1);
         chk("hold_op", 32'(cmdOp), 32'h1);
         chk("hold_rowcol", 32'({cmdRow, cmdCol}), 32'h23);
      end
      cmdReady = 1'b1;
      tick();
      cmdReady = 1'b0;
      chk("post_xfer_valid", 32'(cmdValid), 0);
      chk("post_xfer_op", 32'(cmdOp), 0);
      chk_cursor("post_xfer");

      // Two presses 4 cycles apart should issue FLAG on the next cycle, with no REVEAL.
      sb.push_back('{op: 2'b10, row: 4'd2, col: 4'd3});
      idle_key(4'b0001);
      tick();
      tick();
      tick();
      chk("armed_valid", 32'(cmdValid), 0);
      keyPulse = 4'b0001;
      tick();
      keyPulse = 4'b0000;
      chk("flag_valid", 32'(cmdValid), 1);
      chk("flag_op", 32'(cmdOp), 32'h2);
      cmdReady = 1'b1;
      tick();
      chk("b2b_valid", 32'(cmdValid), 0);
      for (int i = 0; i < 12; i++) tick();
      chk("no_reveal_valid", 32'(cmdValid), 0);
      cmdReady = 1'b0;

      // Pressing all keys together arms the FSM and does not move the cursor.
      sb.push_back('{op: 2'b01, row: 4'd2, col: 4'd3});
      idle_key(4'b1111);
      chk_cursor("all_keys");
      chk("all_keys_valid", 32'(cmdValid), 0);
      wait_valid(lat);
      chk("all_keys_issue", 32'(cmdValid), 1);
      keyPulse = 4'b0100;
      tick();
      keyPulse = 4'b0000;
      cmdReady = 1'b1;
      tick();
      cmdReady = 1'b0;
      chk_cursor("issue_inc_ignored");

      // A reset while a command is pending clears every output and abandons the command.
      idle_key(4'b0010);
      idle_key(4'b0001);
      wait_valid(lat);
      chk("pre_rst_valid", 32'(cmdValid), 1);
      reset = 1'b1;
      cmdReady = 1'b1;
      tick();
      reset = 1'b0;
      exp_row = 0;
      exp_col = 0;
      exp_axis = 1'b0;
      chk("mid_rst_valid", 32'(cmdValid), 0);
      chk("mid_rst_op", 32'(cmdOp), 0);
      chk("mid_rst_cmd", 32'({cmdRow, cmdCol}), 0);
      chk_cursor("mid_rst");
      tick();
      tick();
      chk("after_rst_valid", 32'(cmdValid), 0);
      cmdReady = 1'b0;
      tick();
      chk("sb_empty", 32'(sb.size()), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
